// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : Receives PS/2 keyboard frames and decodes set-2 make codes into
//             ASCII. It tracks Shift and strobes framing, parity and timeout
//             errors.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       p_valid,
    output logic       frame_err,
    output logic       shift_on
);

    typedef enum logic [1:0] {
        S_MAKE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_BIT = 4'd10;

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    logic [1:0]  r_clk_sync;
    logic [1:0]  r_dat_sync;
    logic        r_clk_prev;
    logic        w_fall;
    logic        w_dat;
    logic [3:0]  r_bitcnt;
    logic [9:0]  r_frame;
    logic [15:0] r_tocnt;
    logic        w_frame_ok;
    logic        r_byte_stb;
    logic [7:0]  r_byte;
    logic        r_frame_err;
    state_t      r_state;
    state_t      w_state_next;
    logic        r_shift;
    logic        w_shift_next;
    logic [7:0]  r_key;
    logic [7:0]  w_key_next;
    logic        r_pvalid;
    logic        w_pvalid_next;
    logic        w_is_shift;
    logic [8:0]  w_map;

    // Returns {hit, ascii} for a make code; letters follow the Shift state.
    function automatic logic [8:0] f_map(input logic [7:0] code, input logic shift);
        logic [7:0] ch;
        logic       hit;
        logic       letter;
        ch     = 8'h00;
        hit    = 1'b1;
        letter = 1'b1;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;
                    8'h26: ch = 8'h33;  8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;
                    8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
                    8'h46: ch = 8'h39;  8'h29: ch = 8'h20;  8'h5A: ch = 8'd10;
                    8'h66: ch = 8'd8;
                    default: hit = 1'b0;
                endcase
            end
        endcase
        if (letter && shift) begin
            ch = ch - 8'h20;
        end
        return {hit, ch};
    endfunction

    // Reset asserts immediately but releases only on a clean clk edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Two-flop synchronizers plus a history flop for ps2_clk edge detection.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_dat  = r_dat_sync[1];

    // The stop bit is never stored: it is checked live as the 11th sample.
    assign w_frame_ok = ~r_frame[0] & w_dat & (^r_frame[9:1]);

    // Frame assembly, validation and mid-frame timeout.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bitcnt    <= 4'd0;
            r_frame     <= 10'd0;
            r_tocnt     <= 16'd0;
            r_byte_stb  <= 1'b0;
            r_byte      <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_tocnt <= 16'd0;
                if (r_bitcnt == c_LAST_BIT) begin
                    r_bitcnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte_stb <= 1'b1;
                        r_byte     <= r_frame[8:1];
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                    r_frame  <= {w_dat, r_frame[9:1]};
                end
            end else if (r_bitcnt == 4'd0) begin
                r_tocnt <= 16'd0;
            end else if (r_tocnt == TIMEOUT - 16'd1) begin
                r_tocnt     <= 16'd0;
                r_bitcnt    <= 4'd0;
                r_frame_err <= 1'b1;
            end else begin
                r_tocnt <= r_tocnt + 16'd1;
            end
        end
    end

    assign w_is_shift = (r_byte == 8'h12) || (r_byte == 8'h59);

    // Scancode state machine: prefixes steer state, make codes produce keys.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_key_next    = r_key;
        w_pvalid_next = 1'b0;
        w_map         = f_map(r_byte, r_shift);
        if (r_byte_stb) begin
            case (r_state)
                S_MAKE: begin
                    if (r_byte == 8'hF0) begin
                        w_state_next = S_BRK;
                    end else if (r_byte == 8'hE0) begin
                        w_state_next = S_EXT;
                    end else if (w_is_shift) begin
                        w_shift_next = 1'b1;
                    end else if (w_map[8]) begin
                        w_key_next    = w_map[7:0];
                        w_pvalid_next = 1'b1;
                    end
                end
                S_BRK: begin
                    if (w_is_shift) begin
                        w_shift_next = 1'b0;
                    end
                    w_state_next = S_MAKE;
                end
                S_EXT: begin
                    w_state_next = (r_byte == 8'hF0) ? S_EXT_BRK : S_MAKE;
                end
                S_EXT_BRK: begin
                    w_state_next = S_MAKE;
                end
                default: begin
                    w_state_next = S_MAKE;
                end
            endcase
        end
    end

    // Decoder state and output registers.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= S_MAKE;
            r_shift  <= 1'b0;
            r_key    <= 8'h00;
            r_pvalid <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_key    <= w_key_next;
            r_pvalid <= w_pvalid_next;
        end
    end

    assign key_in    = r_key;
    assign p_valid   = r_pvalid;
    assign frame_err = r_frame_err;
    assign shift_on  = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Purpose  : Directed self-checking bench for ps2_key_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int          HALF = 8;
    localparam logic [15:0] TO   = 16'd100;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_in;
    logic       p_valid;
    logic       frame_err;
    logic       shift_on;

    int         errors    = 0;
    int         checks    = 0;
    int         cyc       = 0;
    int         pv_cnt    = 0;
    int         fe_cnt    = 0;
    int         both_cnt  = 0;
    int         pv_cyc    = 0;
    int         fe_cyc    = 0;
    int         last_fall = 0;
    logic [7:0] last_key  = 8'h00;

    ps2_key_decoder #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_in    (key_in),
        .p_valid   (p_valid),
        .frame_err (frame_err),
        .shift_on  (shift_on)
    );

    always #5 clk = ~clk;

    // Strobe monitor sampled on the falling clk edge.
    always @(negedge clk) begin
        cyc++;
        if (p_valid) begin
            pv_cnt++;
            pv_cyc   = cyc;
            last_key = key_in;
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (p_valid && frame_err) begin
            both_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            idle(HALF);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            idle(HALF);
            ps2_clk = 1'b1;
        end
        idle(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, 11);
    endtask

    task automatic test_reset;
        idle(3);
        checks++; if (key_in !== 8'h00) begin errors++; $display("FAIL reset_key got=%h exp=00", key_in); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_pvalid got=%b exp=0", p_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        checks++; if (shift_on !== 1'b0) begin errors++; $display("FAIL reset_shift got=%b exp=0", shift_on); end
        reset = 1'b1;
        idle(8);
        checks++; if (pv_cnt + fe_cnt !== 0) begin errors++; $display("FAIL reset_release_strobes got=%0d exp=0", pv_cnt + fe_cnt); end
    endtask

    task automatic test_single_key;
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h1C);
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL single_pv_count got=%0d exp=1", pv_cnt - pv0); end
        checks++; if (last_key !== 8'h61) begin errors++; $display("FAIL single_key got=%h exp=61", last_key); end
        checks++; if (key_in !== 8'h61) begin errors++; $display("FAIL single_key_hold got=%h exp=61", key_in); end
        checks++; if (pv_cyc - last_fall !== 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", pv_cyc - last_fall); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_shift;
        int pv0;
        pv0 = pv_cnt;
        send_byte(8'h12);
        checks++; if (shift_on !== 1'b1) begin errors++; $display("FAIL shift_set got=%b exp=1", shift_on); end
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL shift_no_pv got=%0d exp=0", pv_cnt - pv0); end
        send_byte(8'h1C);
        checks++; if (last_key !== 8'h41) begin errors++; $display("FAIL shift_upper got=%h exp=41", last_key); end
        send_byte(8'hF0); send_byte(8'h1C);
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL shift_break_letter got=%0d exp=1", pv_cnt - pv0); end
        send_byte(8'hF0); send_byte(8'h12);
        checks++; if (shift_on !== 1'b0) begin errors++; $display("FAIL shift_clear got=%b exp=0", shift_on); end
        send_byte(8'h1C);
        checks++; if (last_key !== 8'h61) begin errors++; $display("FAIL shift_lower got=%h exp=61", last_key); end
        checks++; if (pv_cnt - pv0 !== 2) begin errors++; $display("FAIL shift_pv_total got=%0d exp=2", pv_cnt - pv0); end
        send_byte(8'h59); send_byte(8'h35);
        checks++; if (last_key !== 8'h59) begin errors++; $display("FAIL rshift_upper got=%h exp=59", last_key); end
        send_byte(8'hF0); send_byte(8'h59);
        checks++; if (shift_on !== 1'b0) begin errors++; $display("FAIL rshift_clear got=%b exp=0", shift_on); end
    endtask

    task automatic test_parity_err;
        int pv0, fe0;
        send_byte(8'h1C);
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_bits(8'h1C, 1'b1, 1'b0, 11);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL parity_ferr got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (fe_cyc - last_fall !== 3) begin errors++; $display("FAIL parity_ferr_timing got=%0d exp=3", fe_cyc - last_fall); end
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL parity_no_pv got=%0d exp=0", pv_cnt - pv0); end
        checks++; if (key_in !== 8'h61) begin errors++; $display("FAIL parity_key_held got=%h exp=61", key_in); end
        send_bits(8'h32, 1'b0, 1'b1, 11);
        checks++; if (fe_cnt - fe0 !== 2) begin errors++; $display("FAIL stop_ferr got=%0d exp=2", fe_cnt - fe0); end
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL stop_no_pv got=%0d exp=0", pv_cnt - pv0); end
    endtask

    task automatic test_extended;
        int pv0;
        pv0 = pv_cnt;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h5A);
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL ext_pv_count got=%0d exp=1", pv_cnt - pv0); end
        checks++; if (key_in !== 8'd10) begin errors++; $display("FAIL ext_enter got=%h exp=0a", key_in); end
        send_byte(8'hE0); send_byte(8'h12);
        checks++; if (shift_on !== 1'b0) begin errors++; $display("FAIL ext_shift_discard got=%b exp=0", shift_on); end
        send_byte(8'h1C);
        checks++; if (last_key !== 8'h61) begin errors++; $display("FAIL ext_back_to_make got=%h exp=61", last_key); end
    endtask

    task automatic test_mapping;
        int pv0;
        send_byte(8'h45);
        checks++; if (last_key !== 8'h30) begin errors++; $display("FAIL map_digit0 got=%h exp=30", last_key); end
        send_byte(8'h12); send_byte(8'h46);
        checks++; if (last_key !== 8'h39) begin errors++; $display("FAIL map_digit9_shift got=%h exp=39", last_key); end
        send_byte(8'h1A);
        checks++; if (last_key !== 8'h5A) begin errors++; $display("FAIL map_upper_z got=%h exp=5a", last_key); end
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h29);
        checks++; if (last_key !== 8'h20) begin errors++; $display("FAIL map_space got=%h exp=20", last_key); end
        send_byte(8'h66);
        checks++; if (last_key !== 8'h08) begin errors++; $display("FAIL map_bksp got=%h exp=08", last_key); end
        pv0 = pv_cnt;
        send_byte(8'h76);
        checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL map_unmapped got=%0d exp=0", pv_cnt - pv0); end
        checks++; if (key_in !== 8'h08) begin errors++; $display("FAIL map_unmapped_hold got=%h exp=08", key_in); end
        pv0 = pv_cnt;
        send_byte(8'h2D); send_byte(8'h2D);
        checks++; if (pv_cnt - pv0 !== 2) begin errors++; $display("FAIL typematic got=%0d exp=2", pv_cnt - pv0); end
        checks++; if (key_in !== 8'h72) begin errors++; $display("FAIL typematic_key got=%h exp=72", key_in); end
    endtask

    task automatic test_timeout;
        int pv0, fe0;
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_bits(8'h16, 1'b0, 1'b0, 5);
        idle(int'(TO) - 40);
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", fe_cnt - fe0); end
        idle(60);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_ferr got=%0d exp=1", fe_cnt - fe0); end
        send_byte(8'h16);
        checks++; if (last_key !== 8'h31) begin errors++; $display("FAIL timeout_recover got=%h exp=31", last_key); end
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL timeout_pv got=%0d exp=1", pv_cnt - pv0); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_ferr_once got=%0d exp=1", fe_cnt - fe0); end
    endtask

    task automatic test_reset_midframe;
        int pv0, fe0;
        send_byte(8'h12);
        checks++; if (shift_on !== 1'b1) begin errors++; $display("FAIL mid_shift_pre got=%b exp=1", shift_on); end
        send_bits(8'h1C, 1'b0, 1'b0, 7);
        reset = 1'b0;
        idle(2);
        checks++; if (key_in !== 8'h00) begin errors++; $display("FAIL mid_key got=%h exp=00", key_in); end
        checks++; if (shift_on !== 1'b0) begin errors++; $display("FAIL mid_shift got=%b exp=0", shift_on); end
        checks++; if (p_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL mid_strobes got=%b%b exp=00", p_valid, frame_err); end
        idle(4);
        pv0 = pv_cnt; fe0 = fe_cnt;
        reset = 1'b1;
        idle(TO + 20);
        checks++; if ((pv_cnt - pv0) + (fe_cnt - fe0) !== 0) begin errors++; $display("FAIL mid_post_release got=%0d exp=0", (pv_cnt - pv0) + (fe_cnt - fe0)); end
        send_byte(8'h1C);
        checks++; if (key_in !== 8'h61) begin errors++; $display("FAIL mid_next_frame got=%h exp=61", key_in); end
        checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL mid_next_pv got=%0d exp=1", pv_cnt - pv0); end
    endtask

    initial begin
        test_reset;
        test_single_key;
        test_shift;
        test_parity_err;
        test_extended;
        test_mapping;
        test_timeout;
        test_reset_midframe;
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pv_ferr_overlap got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16'd20000, meaning idle clk cycles mid-frame before the frame is abandoned.
REQ-002 clk  input  1  system clock; all state SHALL be clocked on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-006 key_in  output  8  ASCII of the last accepted key, consumed by the video-memory writer.
REQ-007 p_valid  output  1  one-cycle strobe: key_in is new this cycle.
REQ-008 frame_err  output  1  one-cycle strobe: a framing, parity or timeout error occurred.
REQ-009 shift_on  output  1  current Shift-held state.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a falling edge SHALL be detected as a sync history of 1 then 0.
REQ-011 Each detected falling edge SHALL sample synchronized ps2_data into an 11-bit frame: start, D0..D7 (LSB first), odd parity, stop. A 4-bit counter SHALL track the position, 0..10.
REQ-012 On the 11th sample, the counter SHALL return to 0. The byte SHALL be accepted only if start==0, stop==1 and ^{D,parity}==1. Otherwise frame_err SHALL pulse in that cycle and the byte SHALL be dropped.
REQ-013 With the counter nonzero, TIMEOUT consecutive cycles without a falling edge SHALL clear the counter and pulse frame_err. The timeout counter SHALL clear on every falling edge and while the counter is 0.
REQ-014 An accepted byte SHALL produce an internal byte strobe in the cycle after the stop-bit sample.
REQ-015 Decoder FSM states SHALL be MAKE, BRK (after F0), EXT (after E0) and EXT_BRK (E0 then F0). All transitions SHALL occur on the byte strobe only.
REQ-016 MAKE: F0->BRK, E0->EXT, other->decode as make and stay in MAKE.
REQ-017 BRK: any byte->handle as break and go to MAKE.
REQ-018 EXT: F0->EXT_BRK, any other byte->discard and go to MAKE.
REQ-019 EXT_BRK: any byte->discard and go to MAKE.
REQ-020 Make 12 or 59 SHALL set shift_on; break 12 or 59 SHALL clear it. Neither SHALL strobe p_valid.
REQ-021 Make mapping (hex scancode->char): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
REQ-022 Letters SHALL map to lowercase ASCII when shift_on==0 and uppercase when shift_on==1.
REQ-023 Digits SHALL map to ASCII '0'..'9' regardless of shift: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
REQ-024 Other keys SHALL map as: 29->8'h20, 5A->8'd10, 66->8'd8.
REQ-025 A mapped make code SHALL register key_in and assert p_valid for exactly one cycle, one cycle after the byte strobe. Total latency from the stop-bit sample SHALL be 2 clk.
REQ-026 Unmapped make codes and all break codes other than Shift SHALL produce no p_valid.
REQ-027 Repeated make codes (typematic) SHALL each produce a p_valid.
REQ-028 key_in SHALL hold its value between strobes.
REQ-029 Shift state updated by a byte SHALL apply from the next byte onward.
REQ-030 frame_err and p_valid SHALL never be asserted for the same frame.

Reset
REQ-031 While reset==0, the block SHALL hold: key_in=8'h00, p_valid=0, frame_err=0, shift_on=0, FSM=MAKE, bit counter=0, timeout counter=0, synchronizers=1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame, and no strobe SHALL follow reset release.
REQ-033 Reset release SHALL be synchronized internally so that the first state update occurs on a clean clk edge.

Verification
REQ-034 Frame 1C with correct parity -> p_valid high for 1 cycle, key_in=8'h61, 2 clk after the stop sample.
REQ-035 Bytes 12, 1C, F0 1C, F0 12, 1C -> key_in 8'h41 then 8'h61, with exactly 2 p_valid pulses, and shift_on 1 then 0.
REQ-036 Frame 1C with parity bit flipped -> frame_err pulses once, no p_valid, and key_in unchanged.
REQ-037 Bytes E0 75, E0 F0 75, then 5A -> exactly 1 p_valid, key_in=8'd10, and the FSM back in MAKE.
REQ-038 Feed 5 bits of a frame, then stop for TIMEOUT cycles, then a full 16 frame -> frame_err once, then key_in=8'h31.
REQ-039 Pull reset low after bit 6 of a 1C frame -> all outputs reset, and no strobe after release. The next full 1C frame -> key_in=8'h61.
